// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM states and access-size helpers shared by the LSU bus interface.
package lsu_pkg;

   localparam logic [2:0] LSU_LB  = 3'b000;
   localparam logic [2:0] LSU_LH  = 3'b001;
   localparam logic [2:0] LSU_LW  = 3'b010;
   localparam logic [2:0] LSU_LD  = 3'b011;
   localparam logic [2:0] LSU_LBU = 3'b100;
   localparam logic [2:0] LSU_LHU = 3'b101;
   localparam logic [2:0] LSU_LWU = 3'b110;
   localparam logic [2:0] LSU_SB  = 3'b000;
   localparam logic [2:0] LSU_SH  = 3'b001;
   localparam logic [2:0] LSU_SW  = 3'b010;
   localparam logic [2:0] LSU_SD  = 3'b011;

   typedef enum logic [1:0] {S_IDLE, S_BUS0, S_BUS1, S_RESP} lsu_state_t;

   function automatic logic [3:0] lsu_size(input logic [1:0] s);
      return 4'd1 << s;
   endfunction

   function automatic logic lsu_misaligned(input logic [2:0] a, input logic [1:0] s);
      logic [3:0] m;
      m = lsu_size(s) - 4'd1;
      return |(a & m[2:0]);
   endfunction

   function automatic logic lsu_illegal(input logic [2:0] f3, input logic we, input logic x64);
      return f3 == 3'b111 || (we && f3[2]) || (!x64 && (f3 == LSU_LD || f3 == LSU_LWU));
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane placement of store data/enables and load merge, extract and extend.
// With LSU_MISALIGN_SPLIT_EN it also produces the second-word lanes and the split flag.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [$clog2(XLEN/8)-1:0] off,
   input  logic [2:0]                f3,
   input  logic [XLEN-1:0]           wdata,
   input  logic [XLEN-1:0]           lo,
   input  logic [XLEN-1:0]           hi,
   output logic [XLEN/8-1:0]         be0,
   output logic [XLEN-1:0]           wd0,
`ifdef LSU_MISALIGN_SPLIT_EN
   output logic [XLEN/8-1:0]         be1,
   output logic [XLEN-1:0]           wd1,
   output logic                      split,
`endif
   output logic [XLEN-1:0]           ld_data
);

   localparam int NB = XLEN / 8;

   logic [7:0]      m8;
   logic [NB-1:0]   mask;
   logic [XLEN-1:0] lane, low;
   logic            sgn;

   assign m8   = 8'((9'd1 << lsu_size(f3[1:0])) - 9'd1);
   assign mask = m8[NB-1:0];

`ifdef LSU_MISALIGN_SPLIT_EN
   assign {be1, be0} = {{NB{1'b0}}, mask} << off;
   assign {wd1, wd0} = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
   assign split      = |be1;
`else
   assign be0 = mask << off;
   assign wd0 = wdata << {off, 3'b000};
`endif

   // hi:lo holds both bus words; shifting right by the offset right-aligns the access
   assign lane = XLEN'({hi, lo} >> {off, 3'b000});

   always_comb begin
      low = '0;
      for (int i = 0; i < NB; i++) low[8*i +: 8] = {8{mask[i]}};
   end

   assign sgn = ~f3[2] & (f3[1:0] == 2'd0 ? lane[7]  :
                          f3[1:0] == 2'd1 ? lane[15] :
                          f3[1:0] == 2'd2 ? lane[31] : lane[XLEN-1]);
   assign ld_data = (lane & low) | (sgn ? ~low : '0);

endmodule

// File: rtl/lsu_bus_if.sv
// lsu_bus_if: MEM-stage load/store unit on a req/ack data bus with wait states and optional timeout.
// Define LSU_MISALIGN_SPLIT_EN to service misaligned accesses (split over two words) instead of erroring.
module lsu_bus_if
   import lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_type,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err,
   output logic              stall_o,
   output logic              bus_req,
   output logic              bus_we,
   output logic [XLEN-1:0]   bus_addr,
   output logic [XLEN-1:0]   bus_wdata,
   output logic [XLEN/8-1:0] bus_be,
   input  logic              bus_ack,
   input  logic [XLEN-1:0]   bus_rdata
);

   localparam int NB = XLEN / 8;
   localparam int LB = $clog2(NB);
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

   lsu_state_t      state;
   logic            we_q, idle, bad, timed_out;
   logic [2:0]      f3_q, f3;
   logic [LB-1:0]   off_q, off;
   logic [XLEN-1:0] wdata_q, wd_in, lo, wd0, ld_data;
   logic [NB-1:0]   be0;
   logic [CW-1:0]   cnt;

   // In IDLE the aligner sees the incoming request so lanes are ready at acceptance
   assign idle  = state == S_IDLE;
   assign off   = idle ? req_addr[LB-1:0] : off_q;
   assign f3    = idle ? req_type : f3_q;
   assign wd_in = idle ? req_wdata : wdata_q;

`ifdef LSU_MISALIGN_SPLIT_EN
   logic [XLEN-1:0] rd0_q, wd1;
   logic [NB-1:0]   be1;
   logic            split;
   assign bad = lsu_illegal(req_type, req_we, XLEN == 64);
   assign lo  = state == S_BUS1 ? rd0_q : bus_rdata;
`else
   assign bad = lsu_illegal(req_type, req_we, XLEN == 64) || lsu_misaligned(req_addr[2:0], req_type[1:0]);
   assign lo  = bus_rdata;
`endif

   assign timed_out = TIMEOUT > 0 && cnt == CW'(TIMEOUT - 1);

   lsu_align #(.XLEN(XLEN)) u_align (
      .off     (off),
      .f3      (f3),
      .wdata   (wd_in),
      .lo      (lo),
      .hi      (bus_rdata),
      .be0     (be0),
      .wd0     (wd0),
`ifdef LSU_MISALIGN_SPLIT_EN
      .be1     (be1),
      .wd1     (wd1),
      .split   (split),
`endif
      .ld_data (ld_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         req_ready  <= 1'b1;
         stall_o    <= 1'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         bus_be     <= '0;
         we_q       <= 1'b0;
         f3_q       <= '0;
         off_q      <= '0;
         wdata_q    <= '0;
         cnt        <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
         rd0_q      <= '0;
`endif
      end else begin
         resp_valid <= 1'b0;
         case (state)
            S_IDLE: if (req_valid) begin
               req_ready <= 1'b0;
               stall_o   <= 1'b1;
               we_q      <= req_we;
               f3_q      <= req_type;
               off_q     <= req_addr[LB-1:0];
               wdata_q   <= req_wdata;
               cnt       <= '0;
               if (bad) begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else begin
                  state     <= S_BUS0;
                  bus_req   <= 1'b1;
                  bus_we    <= req_we;
                  bus_addr  <= {req_addr[XLEN-1:LB], LB'(0)};
                  bus_wdata <= wd0;
                  bus_be    <= be0;
               end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            S_BUS0, S_BUS1:
`else
            S_BUS0:
`endif
               if (bus_ack) begin
                  bus_req    <= 1'b0;
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= we_q ? '0 : ld_data;
`ifdef LSU_MISALIGN_SPLIT_EN
                  // First half of a word-crossing access: keep the bus and move to the next word
                  if (state == S_BUS0 && split) begin
                     bus_req    <= 1'b1;
                     state      <= S_BUS1;
                     resp_valid <= 1'b0;
                     rd0_q      <= bus_rdata;
                     cnt        <= '0;
                     bus_addr   <= bus_addr + XLEN'(NB);
                     bus_wdata  <= wd1;
                     bus_be     <= be1;
                  end
`endif
               end else if (timed_out) begin
                  bus_req    <= 1'b0;
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            S_RESP: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
               stall_o   <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bus_if.sv
// tb_lsu_bus_if: randomized bench for lsu_bus_if (XLEN=32, TIMEOUT=4) against a byte-level access model.
// Expectations follow LSU_MISALIGN_SPLIT_EN when it is defined for the build.
module tb_lsu_bus_if;

   localparam int XLEN = 32;
   localparam int TO   = 4;
`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic        clk = 1'b0, rst = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [2:0]  req_type = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        resp_valid, resp_err, stall_o, bus_req, bus_we;
   logic [31:0] resp_rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;

   int          nvec = 0, nfail = 0;
   logic [31:0] got_rdata;
   logic        got_err;
   int          got_lat;

   lsu_bus_if #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .stall_o(stall_o), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   // Issue one access from a negedge, act as the bus slave, and check every cycle against the model
   task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr, wdata,
                            input logic [31:0] w0, w1, input int t0, t1, input bit noise);
      int          size, ntx, cyc, tx, w, lat, lane;
      bit          illegal, misal, err, tmo, done;
      logic [31:0] a, exp_rd, bm;
      logic [31:0] txa [2];
      logic [31:0] txwd [2];
      logic [31:0] rw [2];
      logic [3:0]  txbe [2];
      int          wt [2];
      size    = 1 << f3[1:0];
      illegal = f3 == 3'b111 || (we && f3[2]) || f3 == 3'b011 || f3 == 3'b110;
      misal   = (addr % size) != 0;
      err     = illegal || (misal && !SPLIT);
      rw[0] = w0; rw[1] = w1; wt[0] = t0; wt[1] = t1;
      for (int i = 0; i < 2; i++) begin txa[i] = '0; txwd[i] = '0; txbe[i] = '0; end
      ntx = 0; exp_rd = '0;
      if (!err) for (int k = 0; k < size; k++) begin
         a = addr + k;
         if (ntx == 0 || txa[ntx-1] != {a[31:2], 2'b00}) begin
            txa[ntx] = {a[31:2], 2'b00};
            ntx++;
         end
         lane = int'(a[1:0]);
         txbe[ntx-1][lane] = 1'b1;
         txwd[ntx-1][8*lane +: 8] = wdata[8*k +: 8];
         exp_rd[8*k +: 8] = rw[ntx-1][8*lane +: 8];
      end
      if (!f3[2] && size < 4 && exp_rd[8*size-1])
         for (int k = size; k < 4; k++) exp_rd[8*k +: 8] = 8'hFF;
      lat = 1; tmo = 0;
      for (int i = 0; i < ntx && !tmo; i++)
         if (wt[i] >= TO) begin lat += TO; tmo = 1; end
         else lat += 1 + wt[i];
      if (tmo) err = 1;
      if (we || err) exp_rd = '0;

      req_valid = 1'b1; req_we = we; req_type = f3; req_addr = addr; req_wdata = wdata;
      nvec++;
      if (req_ready !== 1'b1) begin nfail++; $display("FAIL ready_at_issue: got %b want 1", req_ready); end
      @(posedge clk);
      cyc = 0; tx = 0; w = 0; done = 0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         bus_ack = 1'b0; bus_rdata = $urandom;
         if (resp_valid) begin
            done = 1; req_valid = 1'b0;
            got_rdata = resp_rdata; got_err = resp_err; got_lat = cyc;
            nvec++;
            if (cyc != lat) begin nfail++; $display("FAIL resp_latency: got %0d want %0d", cyc, lat); end
            nvec++;
            if (resp_err !== err) begin nfail++; $display("FAIL resp_err: got %b want %b (type %b addr %h)", resp_err, err, f3, addr); end
            nvec++;
            if (resp_rdata !== exp_rd) begin nfail++; $display("FAIL resp_rdata: got %h want %h (type %b addr %h)", resp_rdata, exp_rd, f3, addr); end
            nvec++;
            if (bus_req !== 1'b0 || stall_o !== 1'b1) begin nfail++; $display("FAIL resp_cycle: bus_req %b stall %b want 0 1", bus_req, stall_o); end
         end else begin
            req_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            req_we = 1'($urandom_range(0, 1)); req_type = 3'($urandom_range(0, 7));
            req_addr = $urandom; req_wdata = $urandom;
            if (bus_req) begin
               nvec++;
               if (tx >= ntx) begin
                  nfail++; $display("FAIL unexpected_bus_req: got addr %h be %b want no transaction", bus_addr, bus_be);
               end else begin
                  for (int k = 0; k < 4; k++) bm[8*k +: 8] = {8{txbe[tx][k]}};
                  if (bus_addr !== txa[tx] || bus_be !== txbe[tx] || bus_we !== we || stall_o !== 1'b1 ||
                      (we && ((bus_wdata ^ txwd[tx]) & bm) != 0)) begin
                     nfail++;
                     $display("FAIL bus_txn%0d: got addr %h be %b we %b wdata %h want addr %h be %b we %b wdata %h",
                              tx, bus_addr, bus_be, bus_we, bus_wdata, txa[tx], txbe[tx], we, txwd[tx]);
                  end
                  if (w == wt[tx]) begin bus_ack = 1'b1; bus_rdata = rw[tx]; tx++; w = 0; end
                  else w++;
               end
            end
         end
      end
      if (!done) begin nvec++; nfail++; $display("FAIL resp_wait: got no resp_valid in 60 cycles want one"); end
      req_valid = 1'b0;
      @(negedge clk);
      bus_ack = 1'b0;
      nvec++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || stall_o !== 1'b0 || bus_req !== 1'b0) begin
         nfail++;
         $display("FAIL after_resp: got ready %b valid %b stall %b bus_req %b want 1 0 0 0", req_ready, resp_valid, stall_o, bus_req);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      nvec++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== '0 || stall_o !== 1'b0 ||
          bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== '0 || bus_wdata !== '0 || bus_be !== '0) begin
         nfail++;
         $display("FAIL reset_values: got ready %b valid %b err %b rdata %h stall %b req %b we %b addr %h wd %h be %b want ready 1 rest 0",
                  req_ready, resp_valid, resp_err, resp_rdata, stall_o, bus_req, bus_we, bus_addr, bus_wdata, bus_be);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_lw_zero_wait;
      do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0);
      nvec++;
      if (got_rdata !== 32'hDEADBEEF || got_err !== 1'b0 || got_lat != 2) begin
         nfail++; $display("FAIL lw_zero_wait: got %h err %b lat %0d want deadbeef 0 2", got_rdata, got_err, got_lat);
      end
   endtask

   task automatic test_byte_offset;
      do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 32'h0, 1, 0, 1'b1);
      nvec++;
      if (got_rdata !== 32'hFFFFFF80) begin nfail++; $display("FAIL lb_sign: got %h want ffffff80", got_rdata); end
      do_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 32'h0, 0, 0, 1'b1);
      nvec++;
      if (got_rdata !== 32'h00000080) begin nfail++; $display("FAIL lbu_zero: got %h want 00000080", got_rdata); end
   endtask

   task automatic test_sh_wait;
      do_access(1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 32'h0, 3, 0, 1'b1);
      nvec++;
      if (got_lat != 5 || got_err !== 1'b0 || got_rdata !== '0) begin
         nfail++; $display("FAIL sh_wait: got lat %0d err %b rdata %h want 5 0 0", got_lat, got_err, got_rdata);
      end
   endtask

   task automatic test_misaligned;
      do_access(1'b0, 3'b010, 32'h102, 32'h0, 32'hAAAA1111, 32'h2222BBBB, 0, 0, 1'b0);
      nvec++;
      if (got_err !== !SPLIT || got_rdata !== (SPLIT ? 32'hBBBBAAAA : 32'h0)) begin
         nfail++; $display("FAIL lw_misaligned: got %h err %b want %h err %b", got_rdata, got_err,
                           SPLIT ? 32'hBBBBAAAA : 32'h0, !SPLIT);
      end
   endtask

   task automatic test_timeout;
      do_access(1'b0, 3'b010, 32'h108, 32'h0, 32'h12345678, 32'h0, 100, 100, 1'b0);
      nvec++;
      if (got_err !== 1'b1 || got_lat != TO + 1) begin
         nfail++; $display("FAIL timeout: got err %b lat %0d want 1 %0d", got_err, got_lat, TO + 1);
      end
      bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      bus_ack = 1'b0;
      nvec++;
      if (resp_valid !== 1'b0 || bus_req !== 1'b0 || req_ready !== 1'b1) begin
         nfail++; $display("FAIL late_ack: got valid %b bus_req %b ready %b want 0 0 1", resp_valid, bus_req, req_ready);
      end
   endtask

   task automatic test_reset_mid;
      req_valid = 1'b1; req_we = 1'b0; req_type = 3'b010; req_addr = 32'h200; req_wdata = '0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      nvec++;
      if (bus_req !== 1'b1) begin nfail++; $display("FAIL mid_bus0: got bus_req %b want 1", bus_req); end
      #2 rst = 1'b0;
      #1;
      nvec++;
      if (bus_req !== 1'b0 || req_ready !== 1'b1 || stall_o !== 1'b0 || resp_valid !== 1'b0) begin
         nfail++; $display("FAIL async_reset: got bus_req %b ready %b stall %b valid %b want 0 1 0 0", bus_req, req_ready, stall_o, resp_valid);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         nvec++;
         if (resp_valid !== 1'b0 || req_ready !== 1'b1 || bus_req !== 1'b0) begin
            nfail++; $display("FAIL post_reset%0d: got valid %b ready %b bus_req %b want 0 1 0", i, resp_valid, req_ready, bus_req);
         end
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 3; i++) begin
         do_access(1'b0, 3'b010, 32'h300 + 32'(4 * i), 32'h0, $urandom, 32'h0, 0, 0, 1'b0);
         nvec++;
         if (got_lat != 2) begin nfail++; $display("FAIL back_to_back%0d: got lat %0d want 2", i, got_lat); end
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 60; i++)
         do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'h100 + $urandom_range(0, 15),
                   $urandom, $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 5), 1'b1);
   endtask

   initial begin
      test_reset();
      test_lw_zero_wait();
      test_byte_offset();
      test_sh_wait();
      test_misaligned();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/lsu_bus_if.md
# lsu_bus_if

Parametrised load/store unit sitting between the MEM stage of the RISC-V pipeline and a handshaked data bus. It replaces the single-cycle, always-ready `ram_*` path with a request/acknowledge bus that supports wait states. It also adds byte enables, sign/zero extension, XLEN of 32 or 64, an optional timeout, and misaligned-access handling. While an access is outstanding it stalls the pipeline.

## Interface

**Parameters**
- `XLEN`, default 32: data/address width; legal values 32 or 64.
- `TIMEOUT`, default 0: maximum wait cycles for `bus_ack` per bus transaction; 0 disables the timeout.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: MEM stage presents an access.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_type` in 3: RISC-V funct3 (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD).
- `req_addr` in XLEN: byte address.
- `req_wdata` in XLEN: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out XLEN: extended load data; 0 for stores and errors.
- `resp_err` out 1: qualifies `resp_valid`; illegal type, misaligned access (macro off), or timeout.
- `stall_o` out 1: high whenever state ≠ IDLE.
- `bus_req` out 1: bus request, registered.
- `bus_we` out 1: bus write enable.
- `bus_addr` out XLEN: word-aligned address (low log2(XLEN/8) bits = 0).
- `bus_wdata` out XLEN: lane-shifted store data.
- `bus_be` out XLEN/8: byte enables.
- `bus_ack` in 1: bus completion; `bus_rdata` is valid in the same cycle.
- `bus_rdata` in XLEN: raw bus word.

## Operation

**States:** IDLE, BUS0, BUS1, RESP.

- **IDLE**
  - The request is accepted on `req_valid && req_ready`, and the request fields are captured.
  - Illegal type → RESP with `resp_err`. Illegal types: 011/110 when XLEN=32; 111; 1xx on a store.
  - Misaligned (`addr % size != 0`) with the macro off → RESP with `resp_err`; no bus cycle is issued.
  - Otherwise → BUS0.
- **BUS0**
  - `bus_req` is high. Address, data and byte enables are held stable until `bus_ack`.
  - On ack, the rdata lanes are latched.
  - → BUS1 if the access is split, else → RESP.
- **BUS1**
  - Second transaction at `bus_addr + XLEN/8`, carrying the remaining lanes.
  - On ack → RESP.
- **RESP**
  - `resp_valid` = 1 for exactly one cycle.
  - For loads, lanes are merged, shifted right, then sign- or zero-extended per type.
  - → IDLE.
- **Timeout:** when `TIMEOUT` > 0, the wait counter resets on entry to BUS0/BUS1. On reaching `TIMEOUT` without ack, `bus_req` drops and the unit goes → RESP with `resp_err`.
- **Bus protocol:** `bus_ack` is ignored outside BUS0/BUS1. `req_valid` is ignored while `req_ready` = 0.

## Timing

- **Reset values:** every output is 0, except `req_ready` = 1. State = IDLE. Reset asserted mid-transaction drops `bus_req` immediately (asynchronously) and discards the access.
- **Zero-wait load:** accept at cycle 0, `bus_req` at cycle 1, ack at cycle 1, `resp_valid` at cycle 2. Latency = 2 + wait states (+1 + wait states for a split access).
- **Error without bus cycle:** `resp_valid` with `resp_err` at cycle 1.
- **Back-to-back:** `req_ready` returns the cycle after `resp_valid`, so the minimum issue interval is 3 cycles.
- `stall_o` is registered-state based and glitch-free.

## Configuration

- **`LSU_MISALIGN_SPLIT_EN` defined:**
  - A misaligned access that stays within one bus word uses a single transaction with shifted byte enables.
  - An access that crosses a word boundary is split into two transactions (low word first), and the load data is merged.
  - `resp_err` is never raised for misalignment.
- **Undefined:** any misaligned access returns `resp_err` with no bus traffic, and the BUS1 state logic is not compiled.

## Structure

- **Package `lsu_pkg`:**
  - funct3 localparams (`LSU_LB` … `LSU_SD`)
  - state enum
  - size-decode function
- **Sub-module `lsu_align`:** combinational lane shifting for store data and byte enables, plus load merge/extract/extend, parametrised by XLEN. The top level holds the FSM, capture registers and timeout counter.

## Test plan

1. **LW, zero-wait:** XLEN=32, `req_addr` = 0x100, `bus_rdata` = 0xDEADBEEF, ack in cycle 1 → `resp_valid` at cycle 2 with `resp_rdata` = 0xDEADBEEF and `resp_err` = 0.
2. **LB/LBU at offset 3:** addr 0x103, `bus_rdata` = 0x80xxxxxx → LB returns 0xFFFFFF80; LBU returns 0x00000080; `bus_be` = 4'b1000.
3. **SH with 3 wait states:** addr 0x102, wdata 0x1234 → `bus_be` = 4'b1100 and `bus_wdata` = 0x12340000, both held for 4 cycles; `resp_valid` at cycle 5.
4. **Timeout:** `TIMEOUT` = 4 and no ack → `bus_req` high for 4 cycles, then `resp_valid` with `resp_err` = 1; a late ack is ignored.
5. **LW at 0x102:**
   - Macro off → `resp_err` at cycle 1 and no `bus_req`.
   - Macro on → two transactions (0x100 with be 1100, 0x104 with be 0011) with words 0xAAAA_xxxx and 0xxxxx_BBBB → `resp_rdata` = 0xBBBBAAAA.
6. **Reset mid-BUS0:** `bus_req` drops asynchronously with no `resp_valid`, and `req_ready` = 1 after reset is released.
